// File: rtl/counter_mod.sv
//==============================================================================
// Module      : counter_mod
// Description : Parametrised synchronous modulo-MOD up/down counter with
//               synchronous load, registered cascade flags (carry/borrow),
//               combinational end-of-range decodes and optional saturation.
//               Chained instances build multi-digit timer fields: one
//               stage's carry_o/borrow_o feeds the next stage's inc_i/dec_i.
//
// Parameters  : MOD  - counting modulus, q_o ranges 0..MOD-1 (MOD >= 2)
//               W    - width of q_o and d_i (2**W >= MOD)
//               WRAP - 1: wrap at the ends, 0: saturate at the ends
//
// Ports       : clk_i      in   clock, all state changes on rising edge
//               rst_i      in   synchronous active-high reset
//               inc_i      in   count-up request
//               dec_i      in   count-down request
//               load_i     in   synchronous load of d_i
//               d_i        in   load value (clamped to MOD-1)
//               q_o        out  current count
//               carry_o    out  one-cycle pulse after an up-overflow
//               borrow_o   out  one-cycle pulse after a down-underflow
//               at_max_o   out  high while q_o == MOD-1
//               at_zero_o  out  high while q_o == 0
//
// Build option: COUNTER_MOD_EDGE_EN
//               defined   - inc_i/dec_i are level inputs; an event is a
//                           rising edge against a history register
//               undefined - strobe mode, every high cycle is one event
//
// Revision    : 1.0 - initial release
//==============================================================================

`default_nettype none

module counter_mod #(
    parameter int MOD  = 6,
    parameter int W    = 3,
    parameter bit WRAP = 1'b1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic         dec_i,
    input  logic         load_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o,
    output logic         carry_o,
    output logic         borrow_o,
    output logic         at_max_o,
    output logic         at_zero_o
);

    // Range constants held one bit wider than q so MOD == 2**W is
    // representable and the compare/increment cannot alias.
    localparam logic [W:0] c_mod_ext = (W+1)'(MOD);
    localparam logic [W:0] c_max_ext = (W+1)'(MOD - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [W-1:0] q_q;
    logic [W-1:0] q_d;
    logic         carry_q;
    logic         carry_d;
    logic         borrow_q;
    logic         borrow_d;

    // -------------------------------------------------------------------------
    // Event qualification
    // -------------------------------------------------------------------------
    logic w_up_evt;
    logic w_dn_evt;

`ifdef COUNTER_MOD_EDGE_EN
    // History registers reset to 1 so an input already high when reset is
    // released is not mistaken for a fresh press. They track the inputs on
    // every non-reset cycle, including load cycles, so a press that lands
    // on a load is consumed rather than deferred.
    logic inc_q;
    logic dec_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inc_q <= 1'b1;
            dec_q <= 1'b1;
        end else begin
            inc_q <= inc_i;
            dec_q <= dec_i;
        end
    end

    assign w_up_evt = inc_i & ~inc_q;
    assign w_dn_evt = dec_i & ~dec_q;
`else
    assign w_up_evt = inc_i;
    assign w_dn_evt = dec_i;
`endif

    // -------------------------------------------------------------------------
    // Widened arithmetic
    // -------------------------------------------------------------------------
    logic [W:0] w_q_ext;
    logic [W:0] w_d_ext;
    logic [W:0] w_q_inc;
    logic [W:0] w_q_dec;
    logic       w_q_top;
    logic       w_q_bot;
    logic       w_d_ok;

    assign w_q_ext = {1'b0, q_q};
    assign w_d_ext = {1'b0, d_i};
    assign w_q_inc = w_q_ext + 1'b1;
    assign w_q_dec = w_q_ext - 1'b1;

    // ">=" rather than "==" so any out-of-range value is treated as the top
    // end and pulled back into range on the next up event.
    assign w_q_top = (w_q_ext >= c_max_ext);
    assign w_q_bot = (w_q_ext == '0);
    assign w_d_ok  = (w_d_ext < c_mod_ext);

    // Carry-out bits of the widened adders are never needed: the top/bottom
    // compares above already steer around the overflow cases.
    logic w_unused;
    assign w_unused = w_q_inc[W] ^ w_q_dec[W];

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        q_d      = q_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;

        if (load_i) begin
            // Out-of-range load values clamp to the top of the range.
            q_d = w_d_ok ? d_i : c_max_ext[W-1:0];
        end else if (w_up_evt && !w_dn_evt) begin
            if (w_q_top) begin
                carry_d = 1'b1;
                q_d     = WRAP ? '0 : c_max_ext[W-1:0];
            end else begin
                q_d = w_q_inc[W-1:0];
            end
        end else if (w_dn_evt && !w_up_evt) begin
            if (w_q_bot) begin
                borrow_d = 1'b1;
                q_d      = WRAP ? c_max_ext[W-1:0] : '0;
            end else begin
                q_d = w_q_dec[W-1:0];
            end
        end
        // Simultaneous up and down, or no event: hold, flags low.
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q      <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            q_q      <= q_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign q_o       = q_q;
    assign carry_o   = carry_q;
    assign borrow_o  = borrow_q;
    // Decoded from the registered count only, never from the inputs.
    assign at_max_o  = (q_q == c_max_ext[W-1:0]);
    assign at_zero_o = (q_q == '0);

endmodule

`default_nettype wire

// File: tb/tb_counter_mod.sv
//==============================================================================
// Module      : tb_counter_mod
// Description : Directed self-checking bench for counter_mod. Covers the
//               wrapping mod-6 counter, a saturating mod-6 counter, a
//               mod-8 (2**W) counter and a mod-10/mod-6 cascade. Handles
//               both the strobe build and the COUNTER_MOD_EDGE_EN build.
// Revision    : 1.0 - initial release
//==============================================================================

`default_nettype none

module tb_counter_mod;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Wrapping mod-6
    logic       inc = 1'b0, dec = 1'b0, load = 1'b0;
    logic [2:0] d = '0;
    logic [2:0] q;
    logic       carry, borrow, at_max, at_zero;

    // Saturating mod-6
    logic       inc_s = 1'b0, dec_s = 1'b0, load_s = 1'b0;
    logic [2:0] d_s = '0;
    logic [2:0] q_s;
    logic       carry_s, borrow_s, at_max_s, at_zero_s;

    // Wrapping mod-8 (MOD == 2**W)
    logic       inc8 = 1'b0, dec8 = 1'b0, load8 = 1'b0;
    logic [2:0] d8 = '0;
    logic [2:0] q8;
    logic       carry8, borrow8, at_max8, at_zero8;

    // Cascade: mod-10 low digit, mod-6 high digit
    logic       inc_c = 1'b0;
    logic [3:0] q_lo;
    logic [2:0] q_hi;
    logic       c_lo, b_lo, am_lo, az_lo;
    logic       c_hi, b_hi, am_hi, az_hi;

    counter_mod #(.MOD(6), .W(3), .WRAP(1'b1)) u_wrap (
        .clk_i(clk), .rst_i(rst), .inc_i(inc), .dec_i(dec), .load_i(load),
        .d_i(d), .q_o(q), .carry_o(carry), .borrow_o(borrow),
        .at_max_o(at_max), .at_zero_o(at_zero));

    counter_mod #(.MOD(6), .W(3), .WRAP(1'b0)) u_sat (
        .clk_i(clk), .rst_i(rst), .inc_i(inc_s), .dec_i(dec_s), .load_i(load_s),
        .d_i(d_s), .q_o(q_s), .carry_o(carry_s), .borrow_o(borrow_s),
        .at_max_o(at_max_s), .at_zero_o(at_zero_s));

    counter_mod #(.MOD(8), .W(3), .WRAP(1'b1)) u_mod8 (
        .clk_i(clk), .rst_i(rst), .inc_i(inc8), .dec_i(dec8), .load_i(load8),
        .d_i(d8), .q_o(q8), .carry_o(carry8), .borrow_o(borrow8),
        .at_max_o(at_max8), .at_zero_o(at_zero8));

    counter_mod #(.MOD(10), .W(4), .WRAP(1'b1)) u_lo (
        .clk_i(clk), .rst_i(rst), .inc_i(inc_c), .dec_i(1'b0), .load_i(1'b0),
        .d_i(4'd0), .q_o(q_lo), .carry_o(c_lo), .borrow_o(b_lo),
        .at_max_o(am_lo), .at_zero_o(az_lo));

    counter_mod #(.MOD(6), .W(3), .WRAP(1'b1)) u_hi (
        .clk_i(clk), .rst_i(rst), .inc_i(c_lo), .dec_i(1'b0), .load_i(1'b0),
        .d_i(3'd0), .q_o(q_hi), .carry_o(c_hi), .borrow_o(b_hi),
        .at_max_o(am_hi), .at_zero_o(az_hi));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge, sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset all instances, then leave one idle cycle so edge-mode history
    // registers see the inputs low before the first stimulus.
    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // Cascade stepping with ripple tracking.
    int   hi_pulses = 0;
    int   lo_pulses = 0;
    logic prev_lo   = 1'b0;

    task automatic cstep();
        step();
        if (c_hi) begin
            hi_pulses++;
            chk("casc_ripple", int'(prev_lo), 1);
        end
        if (c_lo) lo_pulses++;
        prev_lo = c_lo;
    endtask

    initial begin
        // ---------------- reset state ----------------
        rst = 1'b1;
        step();
        step();
        chk("rst_q",       int'(q), 0);
        chk("rst_carry",   int'(carry), 0);
        chk("rst_borrow",  int'(borrow), 0);
        chk("rst_at_zero", int'(at_zero), 1);
        chk("rst_at_max",  int'(at_max), 0);
        rst = 1'b0;
        step();

        // ---------------- six up strobes: 1,2,3,4,5,0 ----------------
        for (int i = 1; i <= 6; i++) begin
            inc = 1'b1;
            step();
            chk("up_q",      int'(q), i % 6);
            chk("up_carry",  int'(carry), (i == 6) ? 1 : 0);
            chk("up_at_max", int'(at_max), (i == 5) ? 1 : 0);
            inc = 1'b0;
            step();
            chk("up_carry_gap", int'(carry), 0);
        end

        // ---------------- down from 0, wrapping ----------------
        dec = 1'b1;
        step();
        chk("dn_wrap_q",      int'(q), 5);
        chk("dn_wrap_borrow", int'(borrow), 1);
        dec = 1'b0;
        step();
        chk("dn_wrap_borrow_clr", int'(borrow), 0);
        chk("dn_wrap_hold",       int'(q), 5);

        // ---------------- saturating ends ----------------
        dec_s = 1'b1;
        step();
        chk("sat_dn_q",      int'(q_s), 0);
        chk("sat_dn_borrow", int'(borrow_s), 1);
        dec_s = 1'b0;
        step();
        chk("sat_dn_borrow_clr", int'(borrow_s), 0);
        load_s = 1'b1; d_s = 3'd5;
        step();
        load_s = 1'b0;
        step();
        inc_s = 1'b1;
        step();
        chk("sat_up_q",      int'(q_s), 5);
        chk("sat_up_carry",  int'(carry_s), 1);
        chk("sat_up_at_max", int'(at_max_s), 1);
        inc_s = 1'b0;
        step();
        chk("sat_up_carry_clr", int'(carry_s), 0);

        // ---------------- loads ----------------
        load = 1'b1; d = 3'd3;
        step();
        chk("load3", int'(q), 3);
        d = 3'd7;
        step();
        chk("load7_clamp",  int'(q), 5);
        chk("load7_at_max", int'(at_max), 1);
        d = 3'd2; inc = 1'b1;
        step();
        chk("load_inc_q",     int'(q), 2);
        chk("load_inc_carry", int'(carry), 0);
        load = 1'b0; inc = 1'b0;
        step();
        chk("load_inc_after", int'(q), 2);

        // ---------------- inc and dec together at 2 ----------------
        inc = 1'b1; dec = 1'b1;
        step();
        chk("both_q",      int'(q), 2);
        chk("both_carry",  int'(carry), 0);
        chk("both_borrow", int'(borrow), 0);
        inc = 1'b0; dec = 1'b0;
        step();

        // ---------------- reset together with load ----------------
        rst = 1'b1; load = 1'b1; d = 3'd4;
        step();
        chk("rst_load_q", int'(q), 0);
        rst = 1'b0; load = 1'b0;
        step();

        // ---------------- reset in the same cycle as a wrap ----------------
        load = 1'b1; d = 3'd5;
        step();
        load = 1'b0;
        step();
        inc = 1'b1; rst = 1'b1;
        step();
        chk("rst_wrap_q",     int'(q), 0);
        chk("rst_wrap_carry", int'(carry), 0);
        inc = 1'b0; rst = 1'b0;
        step();

        // ---------------- reset clears a pending carry ----------------
        load = 1'b1; d = 3'd5;
        step();
        load = 1'b0;
        step();
        inc = 1'b1;
        step();
        chk("pend_carry_set", int'(carry), 1);
        inc = 1'b0; rst = 1'b1;
        step();
        chk("pend_carry_clr", int'(carry), 0);
        chk("pend_q",         int'(q), 0);
        rst = 1'b0;
        step();

        // ---------------- MOD == 2**W ----------------
        load8 = 1'b1; d8 = 3'd7;
        step();
        load8 = 1'b0;
        step();
        chk("m8_at_max", int'(at_max8), 1);
        inc8 = 1'b1;
        step();
        chk("m8_wrap_q",     int'(q8), 0);
        chk("m8_wrap_carry", int'(carry8), 1);
        inc8 = 1'b0;
        step();
        dec8 = 1'b1;
        step();
        chk("m8_dn_q",      int'(q8), 7);
        chk("m8_dn_borrow", int'(borrow8), 1);
        dec8 = 1'b0;
        step();

`ifdef COUNTER_MOD_EDGE_EN
        // ---------------- edge mode ----------------
        do_reset();
        inc = 1'b1;
        for (int i = 0; i < 5; i++) step();
        inc = 1'b0;
        step();
        chk("edge_hold5", int'(q), 1);

        rst = 1'b1; inc = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        step();
        step();
        chk("edge_rst_release", int'(q), 0);
        inc = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            inc = 1'b1;
            step();
            inc = 1'b0;
            step();
        end
        chk("edge_three_pulses", int'(q), 3);
`else
        // ---------------- strobe mode: held INC counts every cycle --------
        do_reset();
        inc = 1'b1;
        for (int i = 0; i < 4; i++) step();
        inc = 1'b0;
        chk("strobe_hold4", int'(q), 4);
        step();
        chk("strobe_hold4_after", int'(q), 4);
`endif

        // ---------------- cascade: 60 pulses ----------------
        do_reset();
        prev_lo = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            inc_c = 1'b1;
            cstep();
            inc_c = 1'b0;
            cstep();
            if (i == 35) begin
                chk("casc35_lo", int'(q_lo), 5);
                chk("casc35_hi", int'(q_hi), 3);
            end
        end
        chk("casc_lo_end",    int'(q_lo), 0);
        chk("casc_hi_end",    int'(q_hi), 0);
        chk("casc_hi_pulses", hi_pulses, 1);
        chk("casc_lo_pulses", lo_pulses, 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
